// File: rtl/therm_scan_ctrl.sv
// Serial thermometer-code popcount with illegal-code flag; WIDTH-cycle scan, result held until out_ready.
// THERM_EARLY_EXIT_EN: stop the scan at the first 0 bit and report the run length of ones, err tied low.
module therm_scan_ctrl #(
  parameter int WIDTH = 15,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] y,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [0:WIDTH-1] shreg;
  logic [CNT_W-1:0] idx;
  logic             cur_bit;
  logic             last_bit;
  logic             accept;
`ifndef THERM_EARLY_EXIT_EN
  logic             seen_zero;
`endif

  // The bit under scan always sits at the LSB end (index WIDTH-1) of the shift register.
  assign cur_bit  = shreg[WIDTH-1];
  assign last_bit = (idx == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
`ifdef THERM_EARLY_EXIT_EN
        if (last_bit || !cur_bit) begin
          state_nxt = DONE;
        end
`else
        if (last_bit) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      idx       <= '0;
      y         <= '0;
      err       <= 1'b0;
`ifndef THERM_EARLY_EXIT_EN
      seen_zero <= 1'b0;
`endif
    end else if (accept) begin
      shreg     <= in;
      idx       <= '0;
      y         <= '0;
      err       <= 1'b0;
`ifndef THERM_EARLY_EXIT_EN
      seen_zero <= 1'b0;
`endif
    end else if (state == SCAN) begin
      shreg <= {1'b0, shreg[0:WIDTH-2]};
      idx   <= idx + CNT_W'(1);
`ifdef THERM_EARLY_EXIT_EN
      if (cur_bit) begin
        y <= y + CNT_W'(1);
      end
`else
      if (cur_bit) begin
        y <= y + CNT_W'(1);
        // A one above any zero breaks the thermometer property.
        if (seen_zero) begin
          err <= 1'b1;
        end
      end else begin
        seen_zero <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_therm_scan_ctrl.sv
// Directed bench for therm_scan_ctrl; expectations follow THERM_EARLY_EXIT_EN when defined.
module tb_therm_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:14] in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  y;
  logic        err;

  int checks = 0;
  int errors = 0;

  therm_scan_ctrl #(.WIDTH(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one code, time the scan, check the result and the return to IDLE.
  task automatic run_code(input logic [0:14] code, input int dy, input int de,
                          input int ey, input int ec, input string nm);
    int n;
    int exp_y;
    int exp_e;
    int exp_c;
`ifdef THERM_EARLY_EXIT_EN
    exp_y = ey; exp_e = 0; exp_c = ec;
`else
    exp_y = dy; exp_e = de; exp_c = 15;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in        = code;
    tick();
    in = ~code;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_after_accept: got %b want 0", nm, in_ready);
    end
    checks++;
    if (y !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s clear_on_accept: got y=%0d err=%b want y=0 err=0", nm, y, err);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != exp_c) begin
      errors++;
      $display("FAIL %s scan_cycles: got %0d want %0d", nm, n, exp_c);
    end
    checks++;
    if (y !== 4'(exp_y) || err !== 1'(exp_e)) begin
      errors++;
      $display("FAIL %s result: got y=%0d err=%b want y=%0d err=%0d", nm, y, err, exp_y, exp_e);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'(exp_y)) begin
      errors++;
      $display("FAIL %s idle_after_handshake: got in_ready=%b out_valid=%b y=%0d want 1 0 %0d",
               nm, in_ready, out_valid, y, exp_y);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in        = '0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b y=%0d err=%b want 1 0 0 0",
               in_ready, out_valid, y, err);
    end
  endtask

  task automatic test_basic;
    run_code(15'b000000000000111, 3, 0, 3, 4, "three_ones");
    run_code(15'b111111111111111, 15, 0, 15, 15, "all_ones");
    run_code(15'b000000000000000, 0, 0, 0, 1, "all_zeros");
    run_code(15'b000000011111111, 8, 0, 8, 9, "eight_ones");
  endtask

  task automatic test_illegal;
    run_code(15'b000000000000101, 2, 1, 1, 2, "bubble_low");
    run_code(15'b100000000000000, 1, 1, 0, 1, "msb_only");
  endtask

  task automatic test_hold;
    int n;
    int exp_y;
    int exp_c;
    int exp_y2;
`ifdef THERM_EARLY_EXIT_EN
    exp_c = 4; exp_y = 3; exp_y2 = 4;
`else
    exp_c = 15; exp_y = 3; exp_y2 = 4;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in        = 15'b000000000000111;
    tick();
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != exp_c) begin
      errors++;
      $display("FAIL hold_scan_cycles: got %0d want %0d", n, exp_c);
    end
    for (int i = 0; i < 5; i++) begin
      in = (i % 2 == 0) ? 15'b111111111111111 : 15'b000000000000001;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 4'(exp_y) || err !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got out_valid=%b in_ready=%b y=%0d err=%b want 1 0 %0d 0",
                 i, out_valid, in_ready, y, err, exp_y);
      end
    end
    in        = 15'b000000000001111;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_next_accept: got in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (y !== 4'(exp_y2) || err !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_result: got y=%0d err=%b out_valid=%b want %0d 0 1",
               y, err, out_valid, exp_y2);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan;
    int seen;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in        = 15'b111111111111111;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: got in_ready=%b out_valid=%b y=%0d err=%b want 1 0 0 0",
               in_ready, out_valid, y, err);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_result: got %0d out_valid cycles want 0", seen);
    end
    run_code(15'b000000000000011, 2, 0, 2, 3, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_hold();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/therm_scan_ctrl.md
Name: therm_scan_ctrl

Overview:
- Sequential controller that accepts a WIDTH-bit thermometer code through a valid/ready handshake.
- Scans the code one bit per clock and returns the binary count of ones (0..WIDTH) through a second valid/ready handshake.
- Flags codes that are not legal thermometer codes.
- Serial, multi-cycle counterpart of the combinational 15-to-4 thermometer encoder; used where input arrives from a shared handshake bus.

Parameters:
- WIDTH, 15, number of thermometer input bits.
- CNT_W, 4, width of count output; must equal ceil(log2(WIDTH+1)).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer has a code on in.
- in_ready  output  1  controller can accept a code.
- in  input  [0:WIDTH-1]  thermometer code; in[WIDTH-1] is the LSB (first filled bit), in[0] the MSB.
- out_valid  output  1  y/err hold a result.
- out_ready  input  1  consumer takes the result.
- y  output  [CNT_W-1:0]  number of ones counted.
- err  output  1  code was not a thermometer code.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, out_valid=0, y=0, err=0; in_ready=1 from the first cycle after reset. Reset mid-SCAN or mid-DONE abandons the operation; no result is produced.
- States: IDLE, SCAN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: an edge with in_valid=1 is an accept.
  - Capture in into the shift register; clear count, bit index, seen_zero and err.
  - Go to SCAN.
- SCAN: one bit per edge, starting at in[WIDTH-1] and ending at in[0].
  - Bit=1: count+=1; if seen_zero=1, set err=1.
  - Bit=0: seen_zero=1.
  - After the edge that processes in[0], go to DONE.
  - SCAN lasts exactly WIDTH cycles. out_valid rises WIDTH edges after the accept edge (15 for default).
- DONE: y=count and err are stable while out_valid=1.
  - Hold all outputs while out_ready=0.
  - An edge with out_ready=1 completes the transfer; go to IDLE.
  - No same-cycle pass-through: in_ready rises the cycle after the output handshake.
- y and err keep their last values in IDLE. They clear to 0 on the next accept edge.
- in and in_valid are ignored outside IDLE. Changes to in during SCAN do not affect the result.
- Count never overflows: all ones gives y=WIDTH (4'd15). y is always the popcount of the captured code, including when err=1.

Optional Feature:
- Macro: THERM_EARLY_EXIT_EN.
- Defined:
  - SCAN ends on the edge that processes the first 0 bit, or after WIDTH bits if none.
  - SCAN lasts min(y+1, WIDTH) cycles.
  - y = number of consecutive ones from the LSB.
  - err is tied to 0.
- Undefined: full WIDTH-cycle scan with err detection as above.

Test Plan:
1. Reset, then in=15'b000000000000111 with in_valid=1 and out_ready=1 → in_ready drops next cycle; out_valid=1 exactly 15 edges after accept with y=3, err=0; IDLE one cycle later.
2. in=15'b111111111111111 → y=15, err=0. Then in=15'b000000000000000 → y=0, err=0. Both take 15 SCAN cycles.
3. in=15'b000000000000101 → y=2, err=1. in=15'b100000000000000 → y=1, err=1.
4. out_ready=0 for 5 cycles in DONE, with in_valid=1 and in toggling → y, err and out_valid stable; in_ready=0; no new capture. Then out_ready=1 → IDLE; next code accepted the following cycle.
5. rst_n=0 for one edge during SCAN cycle 7 → next cycle state IDLE, in_ready=1, out_valid=0, y=0, err=0; no result ever appears.
6. With THERM_EARLY_EXIT_EN defined: in=15'b000000000000111 → out_valid after 4 SCAN cycles, y=3. All ones → 15 SCAN cycles, y=15. in=15'b000000000000101 → y=1, err=0.
